// File: rtl/pretrig_gate.sv
// pretrig_gate: gates pre-trigger requests into a delayed, fixed-width
// DAQ trigger with ack/timeout handshake, dead time and rate counters.
module pretrig_gate #(
  parameter int SIZE_DELAY  = 8,
  parameter int PULSE_WIDTH = 4,
  parameter int DEAD_TIME   = 16,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pretrig_in,
  input  logic                  enable,
  input  logic [SIZE_DELAY-1:0] gate_delay,
  input  logic                  daq_busy,
  input  logic                  daq_ack,
  input  logic                  cnt_clr,
  output logic                  trig_out,
  output logic                  busy_out,
  output logic                  ack_timeout,
  output logic [CNT_WIDTH-1:0]  cnt_accepted,
  output logic [CNT_WIDTH-1:0]  cnt_rejected
);

  typedef enum logic [2:0] {
    IDLE, DELAY, FIRE, WAIT_ACK, DEAD
  } state_t;

  localparam int TM1 =
    (PULSE_WIDTH > DEAD_TIME) ? PULSE_WIDTH : DEAD_TIME;
  localparam int TMAX =
    (TM1 > ACK_TIMEOUT) ? TM1 : ACK_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1);

  localparam logic [TW-1:0] PW_LAST   = TW'(PULSE_WIDTH - 1);
  localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] DEAD_LAST = TW'(DEAD_TIME - 1);
  localparam logic [TW-1:0] T_ONE     = TW'(1);
  localparam logic [SIZE_DELAY-1:0] D_ONE = SIZE_DELAY'(1);
  localparam logic [CNT_WIDTH-1:0]  C_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  C_MAX = '1;

  state_t                state_q, state_d;
  logic                  p1_q, p1_d;
  logic                  p0_q, p0_d;
  logic                  req_q, req_d;
  logic [SIZE_DELAY-1:0] dly_q, dly_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic                  ack_seen_q, ack_seen_d;
  logic                  trig_q, trig_d;
  logic                  busy_q, busy_d;
  logic                  tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  rej_q, rej_d;
  logic                  accept, reject, tmo_set;

  // Edge detect, FSM next state, sticky flag and saturating counters.
  always_comb begin
    p1_d       = pretrig_in;
    p0_d       = p1_q;
    req_d      = p1_q & ~p0_q;
    state_d    = state_q;
    dly_d      = dly_q;
    tmr_d      = tmr_q;
    ack_seen_d = ack_seen_q;
    tmo_set    = 1'b0;
    accept = req_q & enable & ~daq_busy
           & (state_q == IDLE);
    reject = req_q & enable
           & (daq_busy | (state_q != IDLE));
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          dly_d      = gate_delay;
          tmr_d      = '0;
          ack_seen_d = 1'b0;
          state_d    = (gate_delay != '0) ? DELAY : FIRE;
        end
      end
      DELAY: begin
        dly_d = dly_q - D_ONE;
        if (dly_q == D_ONE) begin
          state_d = FIRE;
          tmr_d   = '0;
        end
      end
      FIRE: begin
        if (daq_ack) ack_seen_d = 1'b1;
        if (tmr_q == PW_LAST) begin
          state_d = WAIT_ACK;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + T_ONE;
        end
      end
      WAIT_ACK: begin
        if (daq_ack | ack_seen_q) begin
          state_d = DEAD;
          tmr_d   = '0;
        end else if (tmr_q == ACK_LAST) begin
          state_d = DEAD;
          tmr_d   = '0;
          tmo_set = 1'b1;
        end else begin
          tmr_d = tmr_q + T_ONE;
        end
      end
      DEAD: begin
        if (tmr_q == DEAD_LAST) begin
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + T_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // trig_out lags FIRE by one cycle so the pulse is a clean flop output
    trig_d = (state_q == FIRE);
    busy_d = (state_d != IDLE);
    tmo_d  = cnt_clr ? 1'b0 : (tmo_q | tmo_set);
    if (cnt_clr)
      acc_d = '0;
    else if (accept && acc_q != C_MAX)
      acc_d = acc_q + C_ONE;
    else
      acc_d = acc_q;
    if (cnt_clr)
      rej_d = '0;
    else if (reject && rej_q != C_MAX)
      rej_d = rej_q + C_ONE;
    else
      rej_d = rej_q;
  end

  // All state registers; reset forces IDLE and drops trig_out at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      p1_q       <= 1'b0;
      p0_q       <= 1'b0;
      req_q      <= 1'b0;
      dly_q      <= '0;
      tmr_q      <= '0;
      ack_seen_q <= 1'b0;
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      tmo_q      <= 1'b0;
      acc_q      <= '0;
      rej_q      <= '0;
    end else begin
      state_q    <= state_d;
      p1_q       <= p1_d;
      p0_q       <= p0_d;
      req_q      <= req_d;
      dly_q      <= dly_d;
      tmr_q      <= tmr_d;
      ack_seen_q <= ack_seen_d;
      trig_q     <= trig_d;
      busy_q     <= busy_d;
      tmo_q      <= tmo_d;
      acc_q      <= acc_d;
      rej_q      <= rej_d;
    end
  end

  assign trig_out     = trig_q;
  assign busy_out     = busy_q;
  assign ack_timeout  = tmo_q;
  assign cnt_accepted = acc_q;
  assign cnt_rejected = rej_q;

endmodule

// File: doc/pretrig_gate.md
Name: pretrig_gate

Overview:
- Downstream stage of the pre-trigger decision logic.
- Takes the raw pre-trigger request and applies a programmable gate delay, a fixed-width trigger pulse and a DAQ acknowledge handshake with timeout.
- Enforces a dead time after each accepted trigger.
- Keeps saturating accepted/rejected counters for rate monitoring.
- Drives the trigger line to the DAQ front end.

Parameters:
SIZE_DELAY, 8, width of gate_delay (max delay 2^SIZE_DELAY-1 cycles)
PULSE_WIDTH, 4, trig_out high time in clk cycles (>=1)
DEAD_TIME, 16, dead-time length in clk cycles after ack/timeout (>=1)
ACK_TIMEOUT, 64, max cycles waited for daq_ack
CNT_WIDTH, 16, width of rate counters

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
pretrig_in  in  1  pre-trigger request level from pre-trigger logic
enable  in  1  gate enable; 0 = requests ignored and not counted
gate_delay  in  SIZE_DELAY  delay from request edge to trig_out, sampled at acceptance
daq_busy  in  1  DAQ cannot take a trigger
daq_ack  in  1  DAQ acknowledge, single-cycle or level
cnt_clr  in  1  synchronous clear of counters and timeout flag
trig_out  out  1  trigger pulse to DAQ
busy_out  out  1  high whenever state != IDLE
ack_timeout  out  1  sticky: an ack timed out
cnt_accepted  out  CNT_WIDTH  accepted triggers, saturating
cnt_rejected  out  CNT_WIDTH  rejected requests, saturating

Behaviour:
- Reset (reset=0, async):
  - state=IDLE.
  - All outputs 0; counters 0; edge-detect registers 0.
  - Release is synchronous to clk.
- Input path: pretrig_in is registered (p1), then delayed once more (p0). req_edge = p1 & ~p0. A level held high produces exactly one edge.
- FSM states: IDLE, DELAY, FIRE, WAIT_ACK, DEAD.
- IDLE:
  - req_edge & enable & ~daq_busy: accept.
    - Latch gate_delay into dly_cnt.
    - cnt_accepted+1.
    - Go to DELAY if gate_delay != 0, else FIRE.
  - req_edge & enable & daq_busy: cnt_rejected+1; stay in IDLE.
  - req_edge & ~enable: ignored, not counted.
- DELAY: dly_cnt decrements each cycle; go to FIRE when dly_cnt==1.
- FIRE:
  - trig_out=1 (registered output) for exactly PULSE_WIDTH cycles.
  - Then go to WAIT_ACK.
  - A daq_ack seen during FIRE is remembered and ends WAIT_ACK on its first cycle.
- WAIT_ACK:
  - daq_ack=1: go to DEAD.
  - After ACK_TIMEOUT cycles without ack: set ack_timeout; go to DEAD.
- DEAD: count DEAD_TIME cycles, then go to IDLE.
- Requests during a non-IDLE state:
  - Any req_edge with enable=1 while state != IDLE increments cnt_rejected.
  - It never queues.
- Latency: with gate_delay=D, trig_out rises at clk edge N+3+D, where N is the first edge sampling pretrig_in=1. With D=0 it rises at N+3.
- Minimum accepted spacing: 3+D+PULSE_WIDTH+(ack latency)+DEAD_TIME cycles.
- enable dropped mid-sequence: the current sequence completes normally.
- Counters:
  - Saturate at all-ones and do not wrap.
  - cnt_clr has priority over a same-cycle increment.
  - cnt_clr also clears ack_timeout.
  - cnt_clr does not affect the FSM.
- Simultaneous daq_ack and timeout expiry in the same cycle: treated as ack, and ack_timeout is not set.
- Reset mid-sequence: trig_out drops immediately (asynchronous) and state returns to IDLE. A level still high on pretrig_in after reset release yields one new edge.

Test Plan:
- Reset, enable=1, gate_delay=0, pulse pretrig_in 1 cycle, ack 2 cycles after the pulse ends -> trig_out high 4 cycles starting edge N+3; busy_out clears 16 cycles after ack; cnt_accepted=1.
- gate_delay=10, pretrig_in held high 50 cycles -> single trig_out at N+13; cnt_accepted=1, cnt_rejected=0.
- Second request 5 cycles after the first accept (DELAY/FIRE), then another during DEAD -> cnt_rejected=2; only one trig_out.
- daq_ack never asserted -> ack_timeout=1 after 64 cycles in WAIT_ACK; FSM passes DEAD and returns to IDLE; cnt_clr then clears ack_timeout and counters.
- daq_busy=1 during a request -> no trig_out, cnt_rejected+1. enable=0 during a request -> no trig_out, both counters unchanged.
- Reset asserted during FIRE -> trig_out 0 immediately, busy_out 0. Force cnt_rejected near max (CNT_WIDTH=4, 20 rejects) -> holds at 15.
